encoder_scan_n: RTL and testbench
=================================

// Module: encoder_scan_n
// PURPOSE
//  Parametrised N-to-log2(N) scanning encoder: successor to the 4-to-2 encoder.
//  Captures an N-bit request vector on a load strobe, then emits the index of
//  every set bit, lowest first, one per valid/ready handshake.
//  Sits between status/IRQ-style bit vectors and index-driven consumers (mux, RAM addr).
// PARAMETERS
//  N  8  number of request bits (2..256); indices 0..N-1
//  W  3  index width; must satisfy 2**W >= N (instantiator sets; not derived)
// PORTS
//  clk      in   1  single clock, rising edge
//  rst_n    in   1  asynchronous, active-low reset
//  load     in   1  capture req this cycle (honoured only when busy==0)
//  req      in   N  request vector sampled on load
//  busy     out  1  scan in progress (state SCAN)
//  y_valid  out  1  y holds a valid index
//  y_ready  in   1  consumer accepts y this cycle
//  y        out  W  index of lowest pending bit
//  last     out  1  y is the final pending index (qualified by y_valid)
//  zero     out  1  one-cycle pulse: load accepted with req==0
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, pending=0, busy=0,
//    y_valid=0, y=0, last=0, zero=0 (and err=0 if ERR_EN is defined).
//  - All outputs registered. Handshake fires when y_valid && y_ready.
//  - FSM IDLE:
//    load && req!=0 -> pending<=req, go to SCAN. Next cycle: y_valid=1, y=lowest set
//      index, busy=1. Latency from load to first index: 1 cycle.
//    load && req==0 -> zero=1 for the next cycle only; stay in IDLE.
//    no load -> hold. y_valid=0.
//  - FSM SCAN:
//    handshake -> clear pending[y].
//      If bits remain: y<=next lowest set index, y_valid stays 1.
//      Else: go to IDLE; y_valid=0, busy=0 next cycle.
//    no handshake -> y, last and y_valid held stable (no change under backpressure).
//    load ignored (busy=1), including the cycle of the final handshake.
//  - Throughput: one index per cycle while y_ready is held at 1.
//  - last = (pending has exactly one bit set) while in SCAN.
//  - Full vector (all N bits set) -> emits 0..N-1 in order, last set at N-1.
//  - Non-power-of-2 N: indices never exceed N-1. Upper y codes are unused.
//  - y is don't-care-free: it holds its last value after the scan ends and
//    reads 0 after reset.
//  - Reset mid-scan: pending discarded and outputs return to reset values
//    immediately (asynchronous).
// CONFIGURATION
//  ENCODER_SCAN_ERR_EN defined: adds output `err` (1 bit). err is sticky and set
//    the cycle after a load is asserted while busy==1; it is cleared only by rst_n.
//    The dropped load is still ignored.
//  ENCODER_SCAN_ERR_EN undefined: no err port. Loads while busy are silently dropped.
// TESTING
//  1 rst_n=0 for 2 clk, then release -> busy=0, y_valid=0, y=0, zero=0.
//  2 N=8. load req=8'b1001_0110, y_ready=1 -> y=1,2,4,7 on 4 consecutive cycles.
//    last=1 only with y=7. busy=0 the cycle after.
//  3 req=8'b0000_1001, y_ready=0 for 3 cycles -> y=0 held, y_valid=1.
//    Then y_ready=1 -> y=3 with last=1, then IDLE.
//  4 load req=0 -> zero=1 for exactly 1 cycle, busy=0, y_valid=0.
//  5 load 8'b0000_0011, then load 8'hFF during scan -> only indices 0,1 emitted.
//    With ENCODER_SCAN_ERR_EN: err=1 and stays 1 until reset.
//  6 N=5, W=3. load 5'b11111 -> y=0..4, last at 4. Then rst_n pulse mid-scan
//    of a second load -> y_valid=0 immediately, busy=0.

Source files
------------

// File: rtl/encoder_scan_n.sv
// encoder_scan_n: captures an N-bit request vector and emits each set index, lowest first, via valid/ready.
// Optional sticky load-while-busy error output when ENCODER_SCAN_ERR_EN is defined.
module encoder_scan_n #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [N-1:0] req,
   output logic         busy,
   output logic         y_valid,
   input  logic         y_ready,
   output logic [W-1:0] y,
   output logic         last,
   output logic         zero
`ifdef ENCODER_SCAN_ERR_EN
  ,output logic         err
`endif
);
   typedef enum logic {IDLE, SCAN} state_t;
   state_t state, state_nx;
   logic [N-1:0] pending, cand;
   logic [W-1:0] lo;
   logic hs, take, one;
   assign busy    = state == SCAN;
   assign y_valid = busy;
   assign hs      = busy && y_ready;
   assign take    = hs || (!busy && load && |req);
   // Next vector to scan: current pending minus the accepted index, or a fresh capture.
   assign cand    = busy ? pending & ~(N'(1) << y) : req;
   assign one     = |cand && ~|(cand & (cand - N'(1)));
   always_comb begin
      lo = '0;
      for (int i = N - 1; i >= 0; i--)
         if (cand[i]) lo = W'(i);
   end
   always_comb begin
      state_nx = state;
      state_nx = (state == IDLE) ? ((load && |req) ? SCAN : IDLE)
                                 : ((hs && ~|cand) ? IDLE : SCAN);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         y       <= '0;
         last    <= 1'b0;
         zero    <= 1'b0;
      end else begin
         if (take) begin
            pending <= cand;
            last    <= one;
            if (|cand) y <= lo;
         end
         zero <= !busy && load && ~|req;
      end
   end
`ifdef ENCODER_SCAN_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err <= 1'b0;
      else        err <= err | (load && busy);
   end
`endif
endmodule

// File: tb/tb_encoder_scan_n.sv
// tb_encoder_scan_n: table-driven check of the N=8 encoder plus hand-written N=5 full-vector and mid-scan reset sequences.
module tb_encoder_scan_n;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n, load, y_ready, busy, y_valid, last, zero;
   logic [7:0] req;
   logic [2:0] y;
   logic rst5_n, load5, ready5, busy5, valid5, last5, zero5;
   logic [4:0] req5;
   logic [2:0] y5;
`ifdef ENCODER_SCAN_ERR_EN
   logic err, err5;
`endif
   int pass = 0, total = 0;

   encoder_scan_n #(.N(8), .W(3)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .req(req), .busy(busy),
      .y_valid(y_valid), .y_ready(y_ready), .y(y), .last(last), .zero(zero)
`ifdef ENCODER_SCAN_ERR_EN
     ,.err(err)
`endif
   );

   encoder_scan_n #(.N(5), .W(3)) dut5 (
      .clk(clk), .rst_n(rst5_n), .load(load5), .req(req5), .busy(busy5),
      .y_valid(valid5), .y_ready(ready5), .y(y5), .last(last5), .zero(zero5)
`ifdef ENCODER_SCAN_ERR_EN
     ,.err(err5)
`endif
   );

   typedef struct {
      logic       ld;
      logic [7:0] rq;
      logic       rdy;
      logic       e_busy;
      logic       e_val;
      logic [2:0] e_y;
      logic       e_last;
      logic       e_zero;
      logic       e_err;
   } vec_t;
   vec_t v[17];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   initial begin
      //          ld    req    rdy   busy  val   y     last  zero  err
      v[0]  = '{1'b1, 8'h96, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
      v[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
      v[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0};
      v[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0};
      v[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0};
      v[5]  = '{1'b1, 8'h09, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0};
      v[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0};
      v[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0};
      v[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0};
      v[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0};
      v[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
      v[11] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0};
      v[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
      v[13] = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0};
      v[14] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1};
      v[15] = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1};
      v[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1};

      rst_n = 1'b0; load = 1'b0; req = '0; y_ready = 1'b0;
      rst5_n = 1'b0; load5 = 1'b0; req5 = '0; ready5 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold_valid", 32'(y_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; rst5_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(y_valid), 32'd0);
      chk("rst_y", 32'(y), 32'd0);
      chk("rst_last", 32'(last), 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
`ifdef ENCODER_SCAN_ERR_EN
      chk("rst_err", 32'(err), 32'd0);
`endif

      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         load = v[i].ld; req = v[i].rq; y_ready = v[i].rdy;
         @(posedge clk); #1;
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'(v[i].e_busy));
         chk($sformatf("v%0d_valid", i), 32'(y_valid), 32'(v[i].e_val));
         chk($sformatf("v%0d_y", i), 32'(y), 32'(v[i].e_y));
         chk($sformatf("v%0d_last", i), 32'(last), 32'(v[i].e_last));
         chk($sformatf("v%0d_zero", i), 32'(zero), 32'(v[i].e_zero));
`ifdef ENCODER_SCAN_ERR_EN
         chk($sformatf("v%0d_err", i), 32'(err), 32'(v[i].e_err));
`endif
      end
      load = 1'b0;

      // N=5 full vector: indices 0..4, last only on 4
      @(negedge clk);
      load5 = 1'b1; req5 = 5'b11111; ready5 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         load5 = 1'b0;
         chk($sformatf("n5_y%0d", k), 32'(y5), 32'(k));
         chk($sformatf("n5_valid%0d", k), 32'(valid5), 32'd1);
         chk($sformatf("n5_last%0d", k), 32'(last5), (k == 4) ? 32'd1 : 32'd0);
      end
      @(posedge clk); #1;
      chk("n5_end_busy", 32'(busy5), 32'd0);
      chk("n5_end_valid", 32'(valid5), 32'd0);
      chk("n5_end_y", 32'(y5), 32'd4);

      // second scan interrupted by an asynchronous reset between edges
      @(negedge clk);
      load5 = 1'b1; req5 = 5'b10110; ready5 = 1'b0;
      @(posedge clk); #1;
      load5 = 1'b0;
      chk("n5_scan2_y", 32'(y5), 32'd1);
      chk("n5_scan2_busy", 32'(busy5), 32'd1);
      #2 rst5_n = 1'b0;
      #1;
      chk("n5_arst_valid", 32'(valid5), 32'd0);
      chk("n5_arst_busy", 32'(busy5), 32'd0);
      chk("n5_arst_y", 32'(y5), 32'd0);
      chk("n5_arst_last", 32'(last5), 32'd0);
      @(negedge clk);
      rst5_n = 1'b1; ready5 = 1'b1;
      @(posedge clk); #1;
      chk("n5_post_valid", 32'(valid5), 32'd0);
      chk("n5_post_busy", 32'(busy5), 32'd0);

      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
